dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Round-robin arbiter that shares the two ports of the 16x8 dual-port RAM (`dpram`) among NREQ independent requesters. Each cycle it grants up to two requests, one on port A and one on port B, blocks same-address write collisions, and returns read data to the originating requester. It sits directly in front of `dpram`; requesters never drive the RAM ports themselves.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 4, address width (matches dpram)
- DW, 8, data width (matches dpram)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- req_ready  out  NREQ  request accepted this cycle (valid & ready = transfer)
- rsp_valid  out  NREQ  read data for requester i valid this cycle
- rsp_rdata  out  NREQ*DW  packed read data
- wea, web  out  1  RAM write enables
- addra, addrb  out  AW  RAM addresses
- dina, dinb  out  DW  RAM write data
- douta, doutb  in  DW  RAM read data, valid the cycle after the address is sampled

## Operation
- Round-robin pointer ptr (reset 0). Scan requesters ptr, ptr+1, ... mod NREQ; first valid one -> candidate A, second -> candidate B.
- Collision: if A and B have equal addresses and at least one is a write, B is not granted (A only). Two reads of the same address are both granted.
- Grant is combinational in the same cycle: req_ready[A]/req_ready[B] = 1; port A/B driven from the granted request; wea/web = grant & req_we. Ungranted port: we=0, addr=0, din=0.
- ptr update on any grant: ptr <= (index of last granted requester + 1) mod NREQ. No grant: ptr unchanged. A requester skipped by a collision therefore heads the next scan.
- Writes produce no response; acceptance is completion.
- Reads: granted requester index and port tagged and pipelined one stage; in the cycle douta/doutb are valid, data is registered into rsp_rdata slot of that requester and rsp_valid bit set the following cycle for exactly one cycle.
- Requester holds req fields stable while valid & !ready.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, wea=web=0, addra=addrb=0, dina=dinb=0, ptr=0. No grants while rst_n=0.
- Read latency: granted in cycle T -> rsp_valid at cycle T+2. Throughput: two accesses per cycle, back-to-back, no bubbles.
- Write in cycle T is visible to a read granted in T+1 or later.
- Same requester may be granted on consecutive cycles; at most one grant per requester per cycle.
- Reset asserted mid-operation: in-flight read tags dropped, no rsp_valid issued for them after reset.
- ptr wraps NREQ-1 -> 0.

## Configuration
- DPRAM_ARB_COLLISION_CHECK_EN defined: collision rule above applies.
- Undefined: no address comparison; A and B always both granted, same-address write result is whatever the RAM does (team treats as undefined data); read responses unaffected.

## Test plan
- Reset: rst_n=0 with all req_valid=1 -> req_ready=0, wea=web=0, rsp_valid=0; ptr=0 after release.
- Two writes then reads: req0 write addr 3 data A5, req1 write addr 5 data 5A in cycle T -> both ready, wea=web=1; reads of 3/5 by req2/req3 at T+1 -> rsp_rdata A5/5A, rsp_valid[2]/[3] at T+3.
- Fairness: all 4 valid reads held for 4 cycles -> grant pairs (0,1),(2,3),(0,1),(2,3).
- Collision (macro defined): req0 write addr 7 data 11, req1 write addr 7 data 22 -> only req0 ready; next cycle req1 granted on port A, final RAM[7]=22.
- Same-address reads: req2 and req3 read addr 3 -> both granted, both rsp_rdata=A5 two cycles later.
- Reset mid-read: read granted at T, rst_n=0 at T+1 -> no rsp_valid at T+2.

Source files
------------

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing the two dpram ports among NREQ requesters.
// Define DPRAM_ARB_COLLISION_CHECK_EN to block same-address write pairs.
module dpram_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*DW-1:0]   rsp_rdata,
  output logic                 wea,
  output logic                 web,
  output logic [AW-1:0]        addra,
  output logic [AW-1:0]        addrb,
  output logic [DW-1:0]        dina,
  output logic [DW-1:0]        dinb,
  input  logic [DW-1:0]        douta,
  input  logic [DW-1:0]        doutb
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NR   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx_a, idx_b, cur, last;
  logic [PW:0]        sum;
  logic               fnd_a, fnd_b;
  logic               gnt_a, gnt_b, coll;
  logic [AW-1:0]      addr_a, addr_b;
  logic               we_a, we_b;

  logic               tag_a_q, tag_a_d;
  logic               tag_b_q, tag_b_d;
  logic [PW-1:0]      tidx_a_q, tidx_a_d;
  logic [PW-1:0]      tidx_b_q, tidx_b_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NREQ*DW-1:0] rsp_rdata_q, rsp_rdata_d;

  // First two valid requesters starting at ptr become port A / port B.
  always_comb begin
    idx_a = '0;
    idx_b = '0;
    fnd_a = 1'b0;
    fnd_b = 1'b0;
    sum   = '0;
    cur   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NR) sum = sum - NR;
      cur = sum[PW-1:0];
      if (rst_n && req_valid[cur]) begin
        if (!fnd_a) begin
          fnd_a = 1'b1;
          idx_a = cur;
        end else if (!fnd_b) begin
          fnd_b = 1'b1;
          idx_b = cur;
        end
      end
    end
  end

  always_comb begin
    addr_a = req_addr[idx_a*AW +: AW];
    addr_b = req_addr[idx_b*AW +: AW];
    we_a   = req_we[idx_a];
    we_b   = req_we[idx_b];
`ifdef DPRAM_ARB_COLLISION_CHECK_EN
    coll = fnd_b && (addr_a == addr_b) && (we_a || we_b);
`else
    coll = 1'b0;
`endif
    gnt_a = fnd_a;
    gnt_b = fnd_b && !coll;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[idx_a] = 1'b1;
    if (gnt_b) req_ready[idx_b] = 1'b1;
    wea   = gnt_a && we_a;
    web   = gnt_b && we_b;
    addra = gnt_a ? addr_a : '0;
    addrb = gnt_b ? addr_b : '0;
    dina  = gnt_a ? req_wdata[idx_a*DW +: DW] : '0;
    dinb  = gnt_b ? req_wdata[idx_b*DW +: DW] : '0;
  end

  // Next scan starts just after the last granted requester.
  always_comb begin
    last  = gnt_b ? idx_b : idx_a;
    ptr_d = ptr_q;
    if (gnt_a) ptr_d = (last == LAST) ? '0 : last + 1'b1;
  end

  always_comb begin
    tag_a_d  = gnt_a && !we_a;
    tag_b_d  = gnt_b && !we_b;
    tidx_a_d = idx_a;
    tidx_b_d = idx_b;
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (tag_a_q) begin
      rsp_valid_d[tidx_a_q] = 1'b1;
      rsp_rdata_d[tidx_a_q*DW +: DW] = douta;
    end
    if (tag_b_q) begin
      rsp_valid_d[tidx_b_q] = 1'b1;
      rsp_rdata_d[tidx_b_q*DW +: DW] = doutb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_a_q     <= 1'b0;
      tag_b_q     <= 1'b0;
      tidx_a_q    <= '0;
      tidx_b_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
      tidx_a_q    <= tidx_a_d;
      tidx_b_q    <= tidx_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural 16x8 dual-port RAM.
// Collision checks follow DPRAM_ARB_COLLISION_CHECK_EN as the RTL does.
module tb_dpram_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_we;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ*DW-1:0]  rsp_rdata;
  logic                wea, web;
  logic [AW-1:0]       addra, addrb;
  logic [DW-1:0]       dina, dinb;
  logic [DW-1:0]       douta, doutb;
  logic [DW-1:0]       mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wea(wea), .web(web),
    .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb),
    .douta(douta), .doutb(doutb)
  );

  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (web) mem[addrb] <= dinb;
    douta <= mem[addra];
    doutb <= mem[addrb];
  end

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    n_chk++;
    if ({wea, web} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_we got %b exp 00", {wea, web});
    end
    n_chk++;
    if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rsp got %b/%h exp 0000/0",
               rsp_valid, rsp_rdata);
    end
    n_chk++;
    if (addra !== 4'h0 || addrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_addr got %h/%h exp 0/0", addra, addrb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_ptr0 got %b exp 0011", req_ready);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 4'h3, 8'hA5);
    set_req(1, 1'b1, 4'h5, 8'h5A);
    #1;
    n_chk++;
    if (req_ready !== 4'b0011 || {wea, web} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_grant got %b we %b exp 0011 we 11",
               req_ready, {wea, web});
    end
    n_chk++;
    if (addra !== 4'h3 || addrb !== 4'h5 ||
        dina !== 8'hA5 || dinb !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_ports got %h %h %h %h exp 3 5 a5 5a",
               addra, addrb, dina, dinb);
    end
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b0, 4'h3, 8'h00);
    set_req(3, 1'b0, 4'h5, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b1100 || {wea, web} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_grant got %b we %b exp 1100 we 00",
               req_ready, {wea, web});
    end
    @(negedge clk);
    clear_reqs();
    #1;
    n_chk++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_early got %b exp 0000", rsp_valid);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 4'b1100) begin
      n_fail++;
      $display("FAIL rd_valid got %b exp 1100", rsp_valid);
    end
    n_chk++;
    if (rsp_rdata[23:16] !== 8'hA5 || rsp_rdata[31:24] !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_data got %h exp 5aa5xxxx", rsp_rdata);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_pulse got %b exp 0000", rsp_valid);
    end
  endtask

  task automatic test_same_addr_read();
    do_reset();
    set_req(2, 1'b0, 4'h3, 8'h00);
    set_req(3, 1'b0, 4'h3, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b1100 || addra !== 4'h3 || addrb !== 4'h3) begin
      n_fail++;
      $display("FAIL same_grant got %b %h %h exp 1100 3 3",
               req_ready, addra, addrb);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 4'b1100 ||
        rsp_rdata[23:16] !== 8'hA5 || rsp_rdata[31:24] !== 8'hA5) begin
      n_fail++;
      $display("FAIL same_rsp got %b %h exp 1100 a5a5xxxx",
               rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'h5, 8'h00);
    for (int c = 0; c < 4; c++) begin
      exp = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      n_chk++;
      if (req_ready !== exp) begin
        n_fail++;
        $display("FAIL fair_c%0d got %b exp %b", c, req_ready, exp);
      end
      if (c >= 2) begin
        n_chk++;
        if (rsp_valid !== exp) begin
          n_fail++;
          $display("FAIL fair_rsp_c%0d got %b exp %b",
                   c, rsp_valid, exp);
        end
      end
      if (c == 2) begin
        n_chk++;
        if (rsp_rdata[7:0] !== 8'h5A) begin
          n_fail++;
          $display("FAIL fair_data got %h exp 5a", rsp_rdata[7:0]);
        end
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_collision();
    do_reset();
    set_req(0, 1'b1, 4'h7, 8'h11);
    set_req(1, 1'b1, 4'h7, 8'h22);
    #1;
`ifdef DPRAM_ARB_COLLISION_CHECK_EN
    n_chk++;
    if (req_ready !== 4'b0001 || {wea, web} !== 2'b10) begin
      n_fail++;
      $display("FAIL coll_block got %b we %b exp 0001 we 10",
               req_ready, {wea, web});
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010 || wea !== 1'b1 ||
        addra !== 4'h7 || dina !== 8'h22) begin
      n_fail++;
      $display("FAIL coll_retry got %b %b %h %h exp 0010 1 7 22",
               req_ready, wea, addra, dina);
    end
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b0, 4'h7, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL coll_rd got %b exp 0100", req_ready);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 4'b0100 || rsp_rdata[23:16] !== 8'h22) begin
      n_fail++;
      $display("FAIL coll_data got %b %h exp 0100 22",
               rsp_valid, rsp_rdata[23:16]);
    end
`else
    n_chk++;
    if (req_ready !== 4'b0011 || {wea, web} !== 2'b11) begin
      n_fail++;
      $display("FAIL nocoll got %b we %b exp 0011 we 11",
               req_ready, {wea, web});
    end
    @(negedge clk);
    clear_reqs();
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(3, 1'b0, 4'h3, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b1000 || addra !== 4'h3) begin
      n_fail++;
      $display("FAIL wrap_single got %b %h exp 1000 3",
               req_ready, addra);
    end
    @(negedge clk);
    set_req(1, 1'b0, 4'h5, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b1010 || addra !== 4'h5 || addrb !== 4'h3) begin
      n_fail++;
      $display("FAIL wrap_ptr got %b %h %h exp 1010 5 3",
               req_ready, addra, addrb);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(1, 1'b0, 4'h3, 8'h00);
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_grant got %b exp 0010", req_ready);
    end
    @(negedge clk);
    clear_reqs();
    set_req(0, 1'b0, 4'h5, 8'h00);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 4'b0000 || addra !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_rst_gnt got %b %h exp 0000 0",
               req_ready, addra);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    n_chk++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rsp got %b exp 0000", rsp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rsp_late got %b exp 0000", rsp_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_addr_read();
    test_fairness();
    test_collision();
    test_wrap();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
